// File: rtl/uart_tx_pkg.sv
// UART transmit controller shared definitions.
// FSM state encoding and TX line mux_sel codes.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data bit counter: clear has priority over enable.
// Ports: CLK, RST (async low), clr, en, cnt (bit index), tc (last bit).
module uart_tx_bit_cnt #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] cnt,
  output logic       tc
);

  assign tc = (cnt == 3'(DATA_WIDTH - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (en) begin
      cnt <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: START, DATA x N, optional PARITY, STOP.
// Ports: CLK, RST (async low), Data_Valid, PAR_EN in; ser_load, ser_en,
// par_calc_en, mux_sel, bit_idx, busy out. Macro UART_TX_PARITY_EN
// enables the parity state and the PAR_EN latch.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_en,
  output logic       par_calc_en,
  output logic [1:0] mux_sel,
  output logic [2:0] bit_idx,
  output logic       busy
);

`ifdef UART_TX_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  state_t     state;
  logic       par_q;
  logic [2:0] cnt;
  logic       tc;
  logic       in_data;

  assign in_data = (state == S_DATA);

  // Accept is only possible from IDLE or STOP (back-to-back)
  assign ser_load = RST && Data_Valid &&
                    ((state == S_IDLE) || (state == S_STOP));

  uart_tx_bit_cnt #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_cnt (
    .CLK (CLK),
    .RST (RST),
    .clr (!in_data || tc),
    .en  (in_data),
    .cnt (cnt),
    .tc  (tc)
  );

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_q <= 1'b0;
    end else if (ser_load) begin
      par_q <= PAR_EN;
    end
  end
`else
  logic unused_par_en;
  assign unused_par_en = PAR_EN;
  assign par_q = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (ser_load) state <= S_START;
        S_START: state <= S_DATA;
        S_DATA:  if (tc) state <= par_q ? S_PAR : S_STOP;
        S_PAR:   state <= S_STOP;
        S_STOP:  state <= ser_load ? S_START : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ser_en      = 1'b0;
    par_calc_en = 1'b0;
    mux_sel     = MUX_STOP;
    bit_idx     = 3'd0;
    busy        = 1'b0;
    case (state)
      S_START: begin
        mux_sel     = MUX_START;
        par_calc_en = HAS_PAR;
        busy        = 1'b1;
      end
      S_DATA: begin
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        bit_idx = cnt;
        busy    = 1'b1;
      end
      S_PAR: begin
        mux_sel = MUX_PAR;
        busy    = 1'b1;
      end
      S_STOP: begin
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl (DATA_WIDTH=8).
// Per-cycle scoreboard plus a table of frame scenarios.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam int DW = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       ser_load;
  logic       ser_en;
  logic       par_calc_en;
  logic [1:0] mux_sel;
  logic [2:0] bit_idx;
  logic       busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Data_Valid  (Data_Valid),
    .PAR_EN      (PAR_EN),
    .ser_load    (ser_load),
    .ser_en      (ser_en),
    .par_calc_en (par_calc_en),
    .mux_sel     (mux_sel),
    .bit_idx     (bit_idx),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] mux;
    logic [2:0] idx;
    logic       sen;
    logic       pce;
    logic       bsy;
  } exp_t;

  typedef struct {
    logic pe;
    int   mid_idx;
    logic b2b;
    int   exp_busy;
  } vec_t;

  exp_t q[$];
  exp_t idle_rec;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(logic [1:0] m, logic [2:0] i,
                              logic s, logic p, logic b);
    exp_t e;
    e.mux = m; e.idx = i; e.sen = s; e.pce = p; e.bsy = b;
    return e;
  endfunction

  function automatic int flen(logic pe);
    return 2 + DW + ((HAS_PAR && pe) ? 1 : 0);
  endfunction

  function automatic void chk(string name, logic [8:0] act,
                              logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b",
               name, $time, act, exp);
    end
  endfunction

  // Expected per-cycle outputs of one frame, starting next cycle
  function automatic void push_frame(logic pe);
    q.push_back(mk(MUX_START, 3'd0, 1'b0, HAS_PAR, 1'b1));
    for (int i = 0; i < DW; i++)
      q.push_back(mk(MUX_DATA, 3'(i), 1'b1, 1'b0, 1'b1));
    if (HAS_PAR && pe)
      q.push_back(mk(MUX_PAR, 3'd0, 1'b0, 1'b0, 1'b1));
    q.push_back(mk(MUX_STOP, 3'd0, 1'b0, 1'b0, 1'b1));
  endfunction

  function automatic logic [8:0] obs();
    return {ser_load, ser_en, par_calc_en, mux_sel, bit_idx, busy};
  endfunction

  // Drive inputs, then compare outputs of the current cycle
  task automatic drive_check(input logic dv, input logic pe,
                             output logic ob);
    exp_t e;
    logic el;
    Data_Valid = dv;
    PAR_EN = pe;
    #1;
    e = (q.size() != 0) ? q.pop_front() : idle_rec;
    el = dv && (e.mux == MUX_STOP);
    chk("cycle", obs(), {el, e.sen, e.pce, e.mux, e.idx, e.bsy});
    ob = busy;
    if (el) push_frame(pe);
  endtask

  task automatic tick(input logic dv, input logic pe, output logic ob);
    @(negedge CLK);
    drive_check(dv, pe, ob);
  endtask

  task automatic run_frame(input logic pe, input int mid_idx,
                           input logic b2b, output int nbusy);
    exp_t cur;
    logic dv, p, ob, done, second;
    nbusy = 0; done = 1'b0; second = 1'b0;
    tick(1'b1, pe, ob);
    for (int c = 0; c < 40 && !done; c++) begin
      cur = (q.size() != 0) ? q[0] : idle_rec;
      dv = 1'b0;
      p = 1'($urandom_range(0, 1));
      if (cur.mux == MUX_DATA && int'(cur.idx) == mid_idx) dv = 1'b1;
      if (b2b && !second && cur.mux == MUX_STOP && cur.bsy) begin
        dv = 1'b1; p = !pe; second = 1'b1;
      end
      tick(dv, p, ob);
      if (ob) nbusy++;
      else done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout busy never dropped nbusy=%0d", nbusy);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic ob;
    int   nb;
    idle_rec = mk(MUX_STOP, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs[0] = '{1'b1, -1, 1'b0, flen(1'b1)};
    vecs[1] = '{1'b0, -1, 1'b0, flen(1'b0)};
    vecs[2] = '{1'b1, -1, 1'b1, flen(1'b1) + flen(1'b0)};
    vecs[3] = '{1'b0, 3, 1'b0, flen(1'b0)};
    vecs[4] = '{1'b1, 3, 1'b0, flen(1'b1)};
    vecs[5] = '{1'b0, -1, 1'b1, flen(1'b0) + flen(1'b1)};

    // Reset state, Data_Valid high must not load
    Data_Valid = 1'b1;
    PAR_EN = 1'b1;
    @(negedge CLK);
    #1;
    chk("reset_state", obs(), 9'b0_0_0_01_000_0);

    // Accept in first clock after reset release
    @(negedge CLK);
    RST = 1'b1;
    drive_check(1'b1, 1'b1, ob);
    for (int c = 0; c < 20; c++) tick(1'b0, 1'b0, ob);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].pe, vecs[v].mid_idx, vecs[v].b2b, nb);
      checks++;
      if (nb != vecs[v].exp_busy) begin
        errors++;
        $display("FAIL busy_len vec%0d got %0d expected %0d",
                 v, nb, vecs[v].exp_busy);
      end
      tick(1'b0, 1'b0, ob);
    end

    // Reset during DATA bit_idx=5
    tick(1'b1, 1'b1, ob);
    for (int c = 0; c < 7; c++) tick(1'b0, 1'b1, ob);
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset", obs(), 9'b0_0_0_01_000_0);
    q.delete();
    @(negedge CLK);
    #1;
    chk("reset_hold", obs(), 9'b0_0_0_01_000_0);
    RST = 1'b1;
    run_frame(1'b0, -1, 1'b0, nb);
    checks++;
    if (nb != flen(1'b0)) begin
      errors++;
      $display("FAIL post_reset_len got %0d expected %0d",
               nb, flen(1'b0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame (legal range 5..8).
REQ-002 SHALL have port CLK  input  1  single clock for all state.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Data_Valid  input  1  one-cycle request to send a new frame.
REQ-005 SHALL have port PAR_EN  input  1  parity bit enable, sampled on frame accept.
REQ-006 SHALL have port ser_load  output  1  load the serializer from the data bus (same cycle as accept).
REQ-007 SHALL have port ser_en  output  1  shift-enable to the serializer, high once per data bit.
REQ-008 SHALL have port par_calc_en  output  1  one-cycle enable to the parity calculator.
REQ-009 SHALL have port mux_sel  output  2  TX line source select (START/STOP/DATA/PARITY).
REQ-010 SHALL have port bit_idx  output  3  index of the data bit currently on the line.
REQ-011 SHALL have port busy  output  1  frame in progress.

Function
REQ-012 SHALL implement the Moore FSM IDLE, START, DATA, PARITY, STOP; all outputs decode from the registered state and bit counter, except ser_load.
REQ-013 In IDLE, Data_Valid=1 SHALL accept the frame: ser_load=1 combinationally in that cycle, PAR_EN latched, next state START.
REQ-014 START SHALL last exactly 1 cycle with mux_sel=START and par_calc_en=1; next state DATA with bit counter=0.
REQ-015 DATA SHALL last exactly DATA_WIDTH cycles with mux_sel=DATA, ser_en=1, bit_idx=counter; counter increments by 1 per cycle.
REQ-016 On the last DATA cycle (counter=DATA_WIDTH-1), the next state SHALL be PARITY if latched PAR_EN=1, else STOP; the counter SHALL clear.
REQ-017 PARITY SHALL last 1 cycle with mux_sel=PARITY; next state STOP.
REQ-018 STOP SHALL last 1 cycle with mux_sel=STOP; if Data_Valid=1, it SHALL assert ser_load, relatch PAR_EN and go to START (back-to-back), else go to IDLE.
REQ-019 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-020 Data_Valid in START, DATA or PARITY SHALL be ignored, with no ser_load and no state change.
REQ-021 Changes to PAR_EN mid-frame SHALL NOT affect the current frame.
REQ-022 In IDLE, mux_sel SHALL be STOP (line idle high), ser_en=0, par_calc_en=0, bit_idx=0.
REQ-023 Frame length SHALL be 1+DATA_WIDTH+PAR+1 cycles; accept-to-start-bit latency SHALL be 1 cycle.
REQ-024 Unreachable state encodings SHALL return to IDLE on the next clock.

Reset
REQ-025 RST=0 SHALL asynchronously force IDLE, counter=0, latched PAR_EN=0, busy=0, ser_en=0, par_calc_en=0, ser_load=0, mux_sel=STOP, bit_idx=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with no STOP cycle emitted.
REQ-027 The first accept SHALL be possible in the first clock after RST deasserts.

Configuration
REQ-028 Macro UART_TX_PARITY_EN SHALL compile in the PARITY state and the PAR_EN latch.
REQ-029 Without UART_TX_PARITY_EN: PAR_EN SHALL be ignored, PARITY SHALL be unreachable, par_calc_en SHALL be held 0, and DATA SHALL always be followed by STOP.

Structure
REQ-030 Shared package uart_tx_pkg SHALL hold the state encoding and mux_sel constants: MUX_START=2'b00, MUX_STOP=2'b01, MUX_DATA=2'b10, MUX_PAR=2'b11.
REQ-031 SHALL contain one natural sub-module, uart_tx_bit_cnt (bit counter with clear/enable/terminal-count), instantiated once; the rest is flat.

Verification
REQ-032 Reset, Data_Valid=1 one cycle, PAR_EN=1, DATA_WIDTH=8 -> mux_sel sequence START, DATA x8 (bit_idx 0..7), PARITY, STOP; busy high 11 cycles; par_calc_en high only in START.
REQ-033 Same stimulus with PAR_EN=0 -> no PARITY cycle; busy high 10 cycles.
REQ-034 Data_Valid held high across the STOP cycle -> ser_load in STOP, next cycle START, busy never drops.
REQ-035 Data_Valid pulsed during DATA bit_idx=3 -> no ser_load, frame unchanged, IDLE after STOP.
REQ-036 RST asserted at DATA bit_idx=5 -> IDLE, mux_sel=STOP, busy=0 asynchronously; the next Data_Valid starts a clean frame.
REQ-037 Build without UART_TX_PARITY_EN, PAR_EN=1 -> frame length 10 cycles, par_calc_en never 1.
